// File: rtl/frac_search_pkg.sv
// frac_search_pkg: shared constants, FSM encoding and width helper for the fractional SAD search
package frac_search_pkg;
    localparam int DEF_GRID      = 5;
    localparam int DEF_BLK_ROWS  = 8;
    localparam int DEF_ROW_SAD_W = 11;
    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SCAN, S_DONE} state_e;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/sad_acc_bank.sv
// sad_acc_bank: per-candidate SAD accumulators with clear, parallel add and registered read-by-index
module sad_acc_bank
    import frac_search_pkg::*;
#(
    parameter int NCAND     = DEF_GRID * DEF_GRID,
    parameter int ROW_SAD_W = DEF_ROW_SAD_W,
    parameter int SAD_W     = DEF_ROW_SAD_W + 3,
    parameter int IW        = 5
) (
    input  logic                       clk,
    input  logic                       clr_i,
    input  logic                       add_i,
    input  logic [NCAND*ROW_SAD_W-1:0] row_sad_i,
    input  logic [IW-1:0]              rd_idx_i,
    output logic [SAD_W-1:0]           rd_sad_o
);
    logic [SAD_W-1:0] acc_q [NCAND];
    // accumulators are cleared at block start, so they carry no reset; read port is one cycle deep
    always_ff @(posedge clk) begin
        for (int k = 0; k < NCAND; k++)
            if (clr_i) acc_q[k] <= '0;
            else if (add_i) acc_q[k] <= acc_q[k] + SAD_W'(row_sad_i[k*ROW_SAD_W +: ROW_SAD_W]);
        rd_sad_o <= acc_q[rd_idx_i];
    end
endmodule

// File: rtl/frac_sad_select.sv
// frac_sad_select: accumulates per-row candidate SADs over a block and picks the minimum (centre wins ties)
module frac_sad_select
    import frac_search_pkg::*;
#(
    parameter int GRID      = DEF_GRID,
    parameter int BLK_ROWS  = DEF_BLK_ROWS,
    parameter int ROW_SAD_W = DEF_ROW_SAD_W,
    localparam int NCAND    = GRID * GRID,
    localparam int SAD_W    = ROW_SAD_W + clog2(BLK_ROWS),
    localparam int MV_W     = clog2(GRID)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NCAND*ROW_SAD_W-1:0] row_sad,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SAD_W-1:0]           best_sad,
    output logic [MV_W-1:0]            mvx,
    output logic [MV_W-1:0]            mvy,
    output logic                       busy
);
    localparam int RCW    = clog2(BLK_ROWS) > 0 ? clog2(BLK_ROWS) : 1;
    localparam int IW     = clog2(NCAND);
    localparam int SCW    = clog2(NCAND + 1);
    localparam int CENTRE = ((GRID - 1) / 2) * GRID + (GRID - 1) / 2;

    state_e           state_q, state_d;
    logic [RCW-1:0]   row_q, row_d;
    logic [SCW-1:0]   scan_q, scan_d;
    logic [SAD_W-1:0] best_q, best_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    cand_q;
    logic [IW-1:0]    rd_idx;
    logic [SAD_W-1:0] rd_sad;
    int               scan_i;
    int               idx_i;

    // scan step 0 reads the centre; steps 1..NCAND-1 walk the other indices in ascending order
    assign scan_i = int'(scan_q);
    assign rd_idx = IW'(scan_i == 0 ? CENTRE : scan_i - 1 < CENTRE ? scan_i - 1 : scan_i < NCAND ? scan_i : 0);
    assign idx_i  = int'(idx_q);

    assign in_ready  = state_q == S_ACCUM && !abort;
    assign out_valid = state_q == S_DONE;
    assign busy      = state_q != S_IDLE;
    assign best_sad  = best_q;
    assign mvx       = MV_W'(idx_i % GRID);
    assign mvy       = MV_W'(idx_i / GRID);

    sad_acc_bank #(
        .NCAND(NCAND), .ROW_SAD_W(ROW_SAD_W), .SAD_W(SAD_W), .IW(IW)
    ) u_bank (
        .clk       (clk),
        .clr_i     (state_q == S_IDLE && start && !abort),
        .add_i     (state_q == S_ACCUM && in_valid && !abort),
        .row_sad_i (row_sad),
        .rd_idx_i  (rd_idx),
        .rd_sad_o  (rd_sad)
    );

    // next-state: abort wins everything; the compare lags the read index by one cycle
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        scan_d  = scan_q;
        best_d  = best_q;
        idx_d   = idx_q;
        if (abort) state_d = S_IDLE;
        else case (state_q)
            S_IDLE: if (start) begin
                state_d = S_ACCUM;
                row_d   = '0;
            end
            S_ACCUM: if (in_valid) begin
                row_d = row_q + 1'b1;
                if (row_q == RCW'(BLK_ROWS - 1)) begin
                    state_d = S_SCAN;
                    scan_d  = '0;
                end
            end
            S_SCAN: begin
                scan_d = scan_q + 1'b1;
                if (scan_q == SCW'(1) || (scan_q != '0 && rd_sad < best_q)) begin
                    best_d = rd_sad;
                    idx_d  = cand_q;
                end
                state_d = scan_q == SCW'(NCAND) ? S_DONE : S_SCAN;
            end
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state, counters and result registers; cand_q tracks which candidate the bank read returns
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            scan_q  <= '0;
            best_q  <= '0;
            idx_q   <= '0;
            cand_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            scan_q  <= scan_d;
            best_q  <= best_d;
            idx_q   <= idx_d;
            cand_q  <= rd_idx;
        end
    end
endmodule

// File: tb/tb_frac_sad_select.sv
// tb_frac_sad_select: randomized and directed scoreboard bench for frac_sad_select
module tb_frac_sad_select;
    localparam int G = 5, R = 8, RW = 11, N = G * G, SW = RW + 3, MW = 3, C = 12;
    localparam int N3 = 9, SW3 = RW + 2;

    typedef struct {int sad; int mx; int my; int due;} exp_t;

    logic clk = 0, reset = 0, start = 0, abort = 0, in_valid = 0, out_ready = 1;
    logic [N*RW-1:0] row_sad = '0;
    logic in_ready, out_valid, busy;
    logic [SW-1:0] best_sad;
    logic [MW-1:0] mvx, mvy;

    logic s3_start = 0, s3_abort = 0, s3_valid = 0, s3_out_ready = 0;
    logic [N3*RW-1:0] s3_row = '0;
    logic s3_in_ready, s3_out_valid, s3_busy;
    logic [SW3-1:0] s3_sad;
    logic [1:0] s3_mvx, s3_mvy;

    int checks = 0, errors = 0, cyc = 0;
    int bv [R][N];
    exp_t sb [$];
    bit seen = 0;

    frac_sad_select dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .row_sad(row_sad),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .best_sad(best_sad), .mvx(mvx), .mvy(mvy), .busy(busy)
    );

    frac_sad_select #(.GRID(3), .BLK_ROWS(4)) dut3 (
        .clk(clk), .reset(reset), .start(s3_start), .abort(s3_abort), .row_sad(s3_row),
        .in_valid(s3_valid), .in_ready(s3_in_ready), .out_valid(s3_out_valid), .out_ready(s3_out_ready),
        .best_sad(s3_sad), .mvx(s3_mvx), .mvy(s3_mvy), .busy(s3_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic fill(input int v);
        for (int b = 0; b < R; b++)
            for (int k = 0; k < N; k++) bv[b][k] = v;
    endtask

    task automatic fill_rand();
        int hi;
        hi = $urandom_range(0, 1) ? 3 : 2047;
        for (int b = 0; b < R; b++)
            for (int k = 0; k < N; k++) bv[b][k] = $urandom_range(0, hi);
    endtask

    // reference: totals per candidate, minimum value, centre preferred on a tie, else lowest index
    task automatic send_block(input bit gap, input bit push);
        int tot [N];
        int b, last, m, win;
        exp_t e;
        b = 0;
        last = 0;
        foreach (tot[k]) tot[k] = 0;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        #1 chk("start_busy", busy, 1);
        for (int t = 0; t < 4 * R && b < R; t++) begin
            in_valid = !gap || (t % 2 == 0);
            for (int k = 0; k < N; k++) row_sad[k*RW +: RW] = in_valid ? RW'(bv[b][k]) : RW'($urandom);
            #1;
            if (in_valid && in_ready) begin
                for (int k = 0; k < N; k++) tot[k] += bv[b][k];
                if (b == R - 1) last = cyc + 1;
                b++;
            end
            @(negedge clk);
        end
        in_valid = 0;
        chk("beats", b, R);
        m = tot[0];
        foreach (tot[k]) if (tot[k] < m) m = tot[k];
        win = -1;
        if (tot[C] == m) win = C;
        else foreach (tot[k]) if (win < 0 && tot[k] == m) win = k;
        e.sad = m;
        e.mx  = win % G;
        e.my  = win / G;
        e.due = last + N + 1;
        if (push) sb.push_back(e);
    endtask

    task automatic wait_idle();
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            #3;
            if (!busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    // monitor: compares every presented result against the scoreboard head, pops on handshake
    always @(negedge clk) begin
        #2;
        if (reset && out_valid) begin
            if (sb.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                if (!seen) chk("latency", cyc, sb[0].due);
                seen = 1;
                chk("best_sad", best_sad, sb[0].sad);
                chk("mvx", mvx, sb[0].mx);
                chk("mvy", mvy, sb[0].my);
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                end
            end
        end
    end

    initial begin
        int e3;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_best_sad", best_sad, 0);
        chk("rst_mvx", mvx, 0);
        chk("rst_mvy", mvy, 0);
        @(negedge clk) reset = 1;

        fill(1);
        for (int b = 0; b < R; b++) bv[b][7] = 0;
        send_block(0, 1);
        wait_idle();

        fill(3);
        send_block(0, 1);
        wait_idle();

        fill(5);
        for (int b = 1; b < R; b++) begin
            bv[b][3] = 0;
            bv[b][20] = 0;
        end
        send_block(0, 1);
        wait_idle();

        fill_rand();
        send_block(0, 1);
        wait_idle();
        send_block(1, 1);
        wait_idle();

        fill_rand();
        out_ready = 0;
        send_block(0, 1);
        for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
        chk("hold_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk) start = (i % 2 == 0);
            #1;
            chk("hold_busy", busy, 1);
            chk("hold_out_valid", out_valid, 1);
        end
        @(negedge clk);
        start = 1;
        out_ready = 1;
        @(negedge clk) start = 0;
        #3 chk("ack_with_start_idle", busy, 0);

        fill(1000);
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        in_valid = 1;
        for (int k = 0; k < N; k++) row_sad[k*RW +: RW] = RW'(1000);
        repeat (4) @(negedge clk);
        abort = 1;
        #1 chk("abort_in_ready", in_ready, 0);
        @(negedge clk);
        abort = 0;
        in_valid = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        fill_rand();
        send_block(0, 1);
        wait_idle();

        fill(2000);
        for (int b = 0; b < R; b++) bv[b][$urandom_range(0, N - 1)] = 1;
        send_block(0, 0);
        repeat (6) @(negedge clk);
        chk("scan_busy", busy, 1);
        #2 reset = 0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_best_sad", best_sad, 0);
        chk("rst_mid_mvx", mvx, 0);
        chk("rst_mid_mvy", mvy, 0);
        chk("rst_mid_out_valid", out_valid, 0);
        @(negedge clk) reset = 1;

        for (int i = 0; i < 6; i++) begin
            fill_rand();
            send_block(1'($urandom_range(0, 1)), 1);
            wait_idle();
        end

        @(negedge clk) s3_start = 1;
        @(negedge clk) s3_start = 0;
        s3_valid = 1;
        for (int k = 0; k < N3; k++) s3_row[k*RW +: RW] = (k == 5) ? RW'(0) : RW'(1);
        repeat (4) @(negedge clk);
        s3_valid = 0;
        e3 = cyc;
        for (int t = 0; t < 100 && !s3_out_valid; t++) @(negedge clk);
        chk("g3_latency", cyc - e3, N3 + 1);
        chk("g3_best_sad", s3_sad, 0);
        chk("g3_mvx", s3_mvx, 2);
        chk("g3_mvy", s3_mvy, 1);
        s3_out_ready = 1;
        @(negedge clk);
        #1 chk("g3_idle", s3_busy, 0);

        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
